// File: rtl/codec_i2c_cfg.sv
// codec_i2c_cfg: pushes a table of 16-bit register words to an audio codec
// over I2C, one START/addr/hi/lo/STOP frame per word, on a single cfg_start.
// Optional feature macro: CODEC_I2C_ACK_CHECK_EN -- when defined, a NACK in
// any ACK slot aborts the frame and re-sends the word up to MAX_RETRY times,
// then flags nack_err/err_word. When undefined, ACK slots are not evaluated.
module codec_i2c_cfg #(
  parameter int         NUM_WORDS = 8,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         QTR_DIV   = 32,
  parameter int         MAX_RETRY = 3,
  parameter int         GAP_Q     = 4
) (
  input  logic                    inclk_i2c,
  input  logic                    i2c_rst_n,
  input  logic [NUM_WORDS*16-1:0] cfg_words,
  input  logic                    cfg_start,
  output logic                    i2c_scl,
  output logic                    i2c_sda_oe,
  input  logic                    i2c_sda_in,
  output logic                    busy,
  output logic                    done,
  output logic                    nack_err,
  output logic [3:0]              err_word
);

`ifdef CODEC_I2C_ACK_CHECK_EN
  localparam logic ACK_CHECK = 1'b1;
`else
  localparam logic ACK_CHECK = 1'b0;
`endif

  localparam int          QW        = $clog2(QTR_DIV);
  localparam logic [QW-1:0] Q_LAST  = QW'(QTR_DIV - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_Q - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, DHI, ACK2, DLO, ACK3, STOP, GAP
  } state_t;

  state_t          state, state_next;
  logic [QW-1:0]   qcnt;
  logic [1:0]      quarter;
  logic [2:0]      bit_cnt;
  logic [7:0]      gap_cnt;
  logic [7:0]      retry_cnt;
  logic [3:0]      word_idx;
  logic [3:0]      load_sel;
  logic [15:0]     cur_word;
  logic [15:0]     sel_word;
  logic [7:0]      tx_byte;
  logic            tx_bit;
  logic            ack_nack;
  logic            nack_pend;
  logic            q_end, sym_end, gap_end, scl_pulse;
  logic            start_pass, next_word, retry_word;
  logic            finish_ok, finish_err, set_nack;

  assign q_end     = (qcnt == Q_LAST);
  assign sym_end   = q_end && (quarter == 2'd3);
  assign gap_end   = q_end && (gap_cnt == GAP_LAST);
  assign scl_pulse = (quarter == 2'd1) || (quarter == 2'd2);
  assign busy      = (state != IDLE);

  // Pick the byte being shifted out in the current data state and its current bit, MSB first.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ADDR:    tx_byte = {DEV_ADDR, 1'b0};
      DHI:     tx_byte = cur_word[15:8];
      DLO:     tx_byte = cur_word[7:0];
      default: tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[3'd7 - bit_cnt];
  end

  // Select the table word to capture when a frame (re)starts.
  always_comb begin
    sel_word = 16'h0000;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (load_sel == 4'(k)) sel_word = cfg_words[k*16 +: 16];
    end
  end

  // State register; reset releases the bus immediately without a STOP.
  always_ff @(posedge inclk_i2c or negedge i2c_rst_n) begin
    if (!i2c_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state decode plus the SCL/SDA waveform for each symbol quarter.
  always_comb begin
    state_next = state;
    start_pass = 1'b0;
    next_word  = 1'b0;
    retry_word = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    set_nack   = 1'b0;
    i2c_scl    = 1'b1;
    i2c_sda_oe = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = START;
          start_pass = 1'b1;
        end
      end
      START: begin
        i2c_sda_oe = quarter[1];
        if (sym_end) state_next = ADDR;
      end
      ADDR, DHI, DLO: begin
        i2c_scl    = scl_pulse;
        i2c_sda_oe = ~tx_bit;
        if (sym_end && bit_cnt == 3'd7) begin
          state_next = (state == ADDR) ? ACK1 : (state == DHI) ? ACK2 : ACK3;
        end
      end
      ACK1, ACK2, ACK3: begin
        i2c_scl = scl_pulse;
        if (sym_end) begin
          if (ACK_CHECK && ack_nack) begin
            state_next = STOP;
            set_nack   = 1'b1;
          end else begin
            state_next = (state == ACK1) ? DHI : (state == ACK2) ? DLO : STOP;
          end
        end
      end
      STOP: begin
        i2c_scl    = (quarter != 2'd0);
        i2c_sda_oe = ~quarter[1];
        if (sym_end) state_next = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (nack_pend) begin
            if (retry_cnt == RETRY_LIM) begin
              state_next = IDLE;
              finish_err = 1'b1;
            end else begin
              state_next = START;
              retry_word = 1'b1;
            end
          end else if (word_idx == LAST_IDX) begin
            state_next = IDLE;
            finish_ok  = 1'b1;
          end else begin
            state_next = START;
            next_word  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    load_sel = start_pass ? 4'd0 : next_word ? (word_idx + 4'd1) : word_idx;
  end

  // Quarter/bit/gap timing, word capture, retry bookkeeping and status flags.
  always_ff @(posedge inclk_i2c or negedge i2c_rst_n) begin
    if (!i2c_rst_n) begin
      qcnt      <= '0;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd0;
      gap_cnt   <= 8'd0;
      retry_cnt <= 8'd0;
      word_idx  <= 4'd0;
      cur_word  <= 16'h0000;
      ack_nack  <= 1'b0;
      nack_pend <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
      err_word  <= 4'd0;
    end else begin
      if (state == IDLE) begin
        qcnt    <= '0;
        quarter <= 2'd0;
      end else if (q_end) begin
        qcnt    <= '0;
        quarter <= (state == GAP) ? 2'd0 : quarter + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      if (state != GAP)  gap_cnt <= 8'd0;
      else if (q_end)    gap_cnt <= gap_cnt + 8'd1;

      if (state == IDLE) bit_cnt <= 3'd0;
      else if ((state == ADDR || state == DHI || state == DLO) && sym_end)
        bit_cnt <= bit_cnt + 3'd1;

      if ((state == ACK1 || state == ACK2 || state == ACK3) && q_end && quarter == 2'd2)
        ack_nack <= i2c_sda_in;

      if (start_pass || next_word || retry_word) begin
        cur_word  <= sel_word;
        nack_pend <= 1'b0;
      end else if (set_nack) begin
        nack_pend <= 1'b1;
      end

      if (start_pass || next_word) retry_cnt <= 8'd0;
      else if (retry_word)         retry_cnt <= retry_cnt + 8'd1;

      if (start_pass) word_idx <= 4'd0;
      else if (next_word && word_idx != LAST_IDX) word_idx <= word_idx + 4'd1;

      done <= finish_ok;

      if (start_pass) begin
        nack_err <= 1'b0;
        err_word <= 4'd0;
      end else if (finish_err && ACK_CHECK) begin
        nack_err <= 1'b1;
        err_word <= word_idx;
      end
    end
  end

endmodule
